// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state type, default width and address check for the register file
package regfile_pkg;
    typedef enum logic {RF_INIT, RF_RUN} rf_state_e;
    localparam int XLEN_DEFAULT = 32;
    function automatic logic rf_addr_ok(input int unsigned addr, input int unsigned nregs);
        return addr != 0 && addr < nregs;
    endfunction
endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one read port with address check, write bypass and optional output register
module rf_read_port import regfile_pkg::*; #(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREGS = 32,
    parameter int NWR = 1,
    parameter int BYPASS = 1,
    parameter int RD_REG = 0,
    parameter int AW = $clog2(NREGS)
) (
    input logic clk,
    input logic rst,
    input logic ready,
    input logic [AW-1:0] raddr,
    input logic [NWR-1:0] wen,
    input logic [NWR-1:0][AW-1:0] waddr,
    input logic [NWR-1:0][XLEN-1:0] wdata,
    input logic [XLEN-1:0] rvalue,
    output logic [XLEN-1:0] rdata
);
    logic [XLEN-1:0] sel, q;
    // a registered read always forwards, so it sees the write committed on its own edge
    always_comb begin
        sel = rvalue;
        for (int p = 0; p < NWR; p++)
            if ((BYPASS != 0 || RD_REG != 0) && wen[p] && waddr[p] == raddr) sel = wdata[p];
        if (!ready || !rf_addr_ok(32'(raddr), NREGS)) sel = '0;
    end
    always_ff @(posedge clk) q <= rst ? '0 : sel;
    assign rdata = RD_REG != 0 ? q : sel;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with post-reset clear sequencer
module regfile_mp import regfile_pkg::*; #(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREGS = 32,
    parameter int NRD = 2,
    parameter int NWR = 1,
    parameter int BYPASS = 1,
    parameter int RD_REG = 0,
    localparam int AW = $clog2(NREGS)
) (
    input logic clk,
    input logic rst,
    output logic ready,
    input logic [NWR-1:0] wen,
    input logic [NWR-1:0][AW-1:0] waddr,
    input logic [NWR-1:0][XLEN-1:0] wdata,
    input logic [NRD-1:0][AW-1:0] raddr,
    output logic [NRD-1:0][XLEN-1:0] rdata
);
    rf_state_e state;
    logic [AW-1:0] cnt;
    logic [NWR-1:0] we;
    logic [XLEN-1:0] mem [NREGS];
    always_comb begin
        we = '0;
        for (int p = 0; p < NWR; p++)
            we[p] = state == RF_RUN && wen[p] && rf_addr_ok(32'(waddr[p]), NREGS);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RF_INIT;
            cnt <= AW'(1);
            ready <= 1'b0;
        end else if (state == RF_INIT) begin
            state <= cnt == AW'(NREGS - 1) ? RF_RUN : RF_INIT;
            ready <= cnt == AW'(NREGS - 1);
            cnt <= cnt + AW'(1);
        end
    end
    // later write ports are applied last, so port 1 wins a collision
    always_ff @(posedge clk) begin
        if (!rst && state == RF_INIT) mem[cnt] <= '0;
        for (int p = 0; p < NWR; p++)
            if (!rst && we[p]) mem[waddr[p]] <= wdata[p];
    end
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        rf_read_port #(
            .XLEN(XLEN), .NREGS(NREGS), .NWR(NWR), .BYPASS(BYPASS), .RD_REG(RD_REG), .AW(AW)
        ) u_rd (
            .clk(clk),
            .rst(rst),
            .ready(ready),
            .raddr(raddr[i]),
            .wen(we),
            .waddr(waddr),
            .wdata(wdata),
            .rvalue(mem[raddr[i]]),
            .rdata(rdata[i])
        );
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench driving a combinational-bypass and a registered-read instance in lockstep
module tb_regfile_mp;
    localparam int NREGS = 32;
    localparam int AW = 5;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] wen = '0;
    logic [1:0][AW-1:0] waddr = '0, raddr = '0;
    logic [1:0][31:0] wdata = '0, rd_c, rd_r;
    logic rdy_c, rdy_r;
    always #5 clk = ~clk;

    regfile_mp #(.XLEN(32), .NREGS(NREGS), .NRD(2), .NWR(2), .BYPASS(1), .RD_REG(0)) dut_c (
        .clk(clk), .rst(rst), .ready(rdy_c), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rd_c)
    );
    regfile_mp #(.XLEN(32), .NREGS(NREGS), .NRD(2), .NWR(2), .BYPASS(0), .RD_REG(1)) dut_r (
        .clk(clk), .rst(rst), .ready(rdy_r), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rd_r)
    );

    typedef struct {
        int cyc;
        logic [31:0] d0, d1;
        logic rdy;
    } exp_t;
    exp_t q_c[$], q_r[$];
    int edges = 0, total = 0, bad = 0;
    logic [31:0] mem [NREGS];
    int init_left = NREGS - 1;

    always @(posedge clk) edges++;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got %h expected %h", n, edges, act, exp);
        end
    endtask

    // reference read: zero until initialised or for r0, else latest write this cycle, else stored value
    function automatic logic [31:0] model_rd(input logic [AW-1:0] a);
        logic [31:0] v;
        if (init_left != 0 || a == 0) return 32'd0;
        v = mem[a];
        for (int p = 0; p < 2; p++) if (wen[p] && waddr[p] == a) v = wdata[p];
        return v;
    endfunction

    task automatic step(input logic [1:0] we, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [AW-1:0] r0, input logic [AW-1:0] r1, input logic r);
        exp_t e;
        wen = we; waddr[0] = a0; waddr[1] = a1; wdata[0] = d0; wdata[1] = d1;
        raddr[0] = r0; raddr[1] = r1; rst = r;
        e.cyc = edges;
        e.rdy = init_left == 0;
        e.d0 = model_rd(r0);
        e.d1 = model_rd(r1);
        q_c.push_back(e);
        if (r) begin
            e.d0 = 32'd0;
            e.d1 = 32'd0;
        end
        q_r.push_back(e);
        if (r) begin
            init_left = NREGS - 1;
            foreach (mem[i]) mem[i] = 32'd0;
        end else if (init_left > 0) init_left--;
        else begin
            if (we[0] && a0 != 0) mem[a0] = d0;
            if (we[1] && a1 != 0) mem[a1] = d1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_step(input logic [1:0] we, input logic r);
        logic [AW-1:0] a0;
        a0 = 5'($urandom);
        step(we, a0, ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom), $urandom, $urandom,
             5'($urandom), ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom), r);
    endtask

    task automatic sweep();
        for (int a = 0; a < NREGS; a += 2) step(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'(a), 5'(a + 1), 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (q_c.size() != 0 && q_c[0].cyc <= edges) begin
            e = q_c.pop_front();
            chk("comb_rd0", rd_c[0], e.d0);
            chk("comb_rd1", rd_c[1], e.d1);
            chk("comb_ready", 32'(rdy_c), 32'(e.rdy));
            chk("reg_ready", 32'(rdy_r), 32'(e.rdy));
        end
        while (q_r.size() != 0 && q_r[0].cyc + 1 <= edges) begin
            e = q_r.pop_front();
            chk("reg_rd0", rd_r[0], e.d0);
            chk("reg_rd1", rd_r[1], e.d1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        foreach (mem[i]) mem[i] = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        n = 0;
        while (!rdy_c && n < 100) begin
            step(2'b01, 5'd5, 5'd0, 32'hDEAD_0000 + 32'(n), 32'd0, 5'($urandom), 5'd5, 1'b0);
            n++;
        end
        chk("ready_edges", 32'(n), 32'(NREGS - 1));
        sweep();
        step(2'b01, 5'd15, 5'd0, 32'hABCDEFAA, 32'd0, 5'd15, 5'd15, 1'b0);
        step(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd15, 5'd15, 1'b0);
        step(2'b01, 5'd0, 5'd0, 32'hFFFFFFFF, 32'd0, 5'd0, 5'd0, 1'b0);
        step(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd5, 1'b0);
        step(2'b11, 5'd7, 5'd7, 32'h1111, 32'h2222, 5'd7, 5'd7, 1'b0);
        step(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd7, 5'd7, 1'b0);
        step(2'b01, 5'd3, 5'd0, 32'h55, 32'd0, 5'd3, 5'd0, 1'b0);
        step(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd3, 5'd7, 1'b0);
        for (int k = 0; k < 100; k++) begin
            rnd_step(2'($urandom), k == 50);
            if (k == 50) begin
                repeat (NREGS - 1) rnd_step(2'($urandom), 1'b0);
                sweep();
            end
        end
        for (int k = 0; k < 100; k++) rnd_step(2'b00, 1'b0);
        @(negedge clk);
        #1;
        chk("queues_drained", 32'(q_c.size() + q_r.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
